zacore_imem: RTL and testbench

ZACORE_IMEM -- requirements
Module: zacore_imem

---
 rtl/zacore_pkg.sv | 12 +
 rtl/zacore_imem_ram.sv | 23 ++
 rtl/zacore_imem.sv | 134 +++++++++++++
 tb/tb_zacore_imem.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/zacore_pkg.sv
// rtl/zacore_pkg.sv - shared zacore constants and types
package zacore_pkg;

  localparam logic [31:0] FAULT_INST = 32'h0000_0000;

  typedef enum logic [1:0] {
    LD_IDLE = 2'd0,
    LD_LOAD = 2'd1,
    LD_DONE = 2'd2
  } load_state_e;

endpackage

// File: rtl/zacore_imem_ram.sv
// rtl/zacore_imem_ram.sv - single-clock 1R1W word RAM, read-first on collision
module zacore_imem_ram #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned AW = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [31:0]   rd_data,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [31:0]   wr_data
);

  logic [31:0] mem [DEPTH_WORDS];

  // Both updates are non-blocking, so a same-word read sees the pre-write value.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/zacore_imem.sv
// rtl/zacore_imem.sv - instruction RAM with fetch port and program-load burst engine
module zacore_imem
  import zacore_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_fetch_req,
  input  logic [31:0] i_fetch_addr,
  output logic [31:0] o_inst_read,
  output logic        o_fetch_fault,
  input  logic        i_load_start,
  input  logic [31:0] i_load_base,
  input  logic [15:0] i_load_count,
  input  logic        i_load_valid,
  input  logic [31:0] i_load_data,
  output logic        o_load_ready,
  output logic        o_load_busy,
  output logic        o_load_done,
  output logic        o_load_err
);

  localparam int unsigned AW   = $clog2(DEPTH_WORDS);
  localparam logic [31:0] SPAN = 32'(DEPTH_WORDS * 4);

  load_state_e state;
  logic [31:0] base_q;
  logic [15:0] count_q;
  logic [15:0] beat_q;
  logic        inst_valid;
  logic [31:0] ram_rdata;

  // Subtracting BASE_ADDR first makes addresses below the window wrap high and fail the span test.
  logic [31:0] fetch_off;
  logic        fetch_ok;
  logic        rd_en;
  assign fetch_off = i_fetch_addr - BASE_ADDR;
  assign fetch_ok  = (i_fetch_addr[1:0] == 2'b00) && (fetch_off < SPAN);
  assign rd_en     = i_fetch_req && !i_rst && fetch_ok;

  logic [31:0] load_addr;
  logic [31:0] load_off;
  logic        load_ok;
  logic        beat;
  logic        wr_en;
  assign load_addr = base_q + {14'd0, beat_q, 2'b00};
  assign load_off  = load_addr - BASE_ADDR;
  assign load_ok   = (load_addr[1:0] == 2'b00) && (load_off < SPAN);
  assign beat      = (state == LD_LOAD) && i_load_valid && !i_rst;
  assign wr_en     = beat && load_ok;

  zacore_imem_ram #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .AW         (AW)
  ) u_ram (
    .clk    (i_clk),
    .rd_en  (rd_en),
    .rd_addr(fetch_off[AW+1:2]),
    .rd_data(ram_rdata),
    .wr_en  (wr_en),
    .wr_addr(load_off[AW+1:2]),
    .wr_data(i_load_data)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      inst_valid    <= 1'b0;
      o_fetch_fault <= 1'b0;
    end else if (i_fetch_req) begin
      inst_valid    <= fetch_ok;
      o_fetch_fault <= !fetch_ok;
    end
  end

  assign o_inst_read = inst_valid ? ram_rdata : FAULT_INST;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state        <= LD_IDLE;
      base_q       <= 32'd0;
      count_q      <= 16'd0;
      beat_q       <= 16'd0;
      o_load_ready <= 1'b0;
      o_load_busy  <= 1'b0;
      o_load_done  <= 1'b0;
      o_load_err   <= 1'b0;
    end else begin
      case (state)
        LD_IDLE: begin
          o_load_done <= 1'b0;
          if (i_load_start) begin
            if (i_load_count != 16'd0) begin
              base_q       <= i_load_base;
              count_q      <= i_load_count;
              beat_q       <= 16'd0;
              o_load_err   <= 1'b0;
              o_load_ready <= 1'b1;
              o_load_busy  <= 1'b1;
              state        <= LD_LOAD;
            end else begin
              o_load_done <= 1'b1;
              state       <= LD_DONE;
            end
          end
        end
        LD_LOAD: begin
          if (beat) begin
            beat_q <= beat_q + 16'd1;
            if (!load_ok) o_load_err <= 1'b1;
            if (beat_q == 16'(count_q - 16'd1)) begin
              o_load_ready <= 1'b0;
              o_load_busy  <= 1'b0;
              o_load_done  <= 1'b1;
              state        <= LD_DONE;
            end
          end
        end
        LD_DONE: begin
          o_load_done <= 1'b0;
          state       <= LD_IDLE;
        end
        default: begin
          o_load_ready <= 1'b0;
          o_load_busy  <= 1'b0;
          o_load_done  <= 1'b0;
          state        <= LD_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_zacore_imem.sv
// tb/tb_zacore_imem.sv - directed self-checking bench for zacore_imem
module tb_zacore_imem;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_fetch_req;
  logic [31:0] i_fetch_addr;
  logic [31:0] o_inst_read;
  logic        o_fetch_fault;
  logic        i_load_start;
  logic [31:0] i_load_base;
  logic [15:0] i_load_count;
  logic        i_load_valid;
  logic [31:0] i_load_data;
  logic        o_load_ready;
  logic        o_load_busy;
  logic        o_load_done;
  logic        o_load_err;

  int vectors = 0;
  int miscompares = 0;

  zacore_imem #(
    .DEPTH_WORDS(1024),
    .BASE_ADDR  (32'h0000_0000)
  ) dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_fetch_req  (i_fetch_req),
    .i_fetch_addr (i_fetch_addr),
    .o_inst_read  (o_inst_read),
    .o_fetch_fault(o_fetch_fault),
    .i_load_start (i_load_start),
    .i_load_base  (i_load_base),
    .i_load_count (i_load_count),
    .i_load_valid (i_load_valid),
    .i_load_data  (i_load_data),
    .o_load_ready (o_load_ready),
    .o_load_busy  (o_load_busy),
    .o_load_done  (o_load_done),
    .o_load_err   (o_load_err)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic start_load(input logic [31:0] base, input logic [15:0] count);
    i_load_start = 1'b1;
    i_load_base  = base;
    i_load_count = count;
    tick();
    i_load_start = 1'b0;
  endtask

  task automatic send_beat(input logic [31:0] data);
    i_load_valid = 1'b1;
    i_load_data  = data;
    tick();
    i_load_valid = 1'b0;
  endtask

  task automatic fetch(input logic [31:0] addr);
    i_fetch_req  = 1'b1;
    i_fetch_addr = addr;
    tick();
    i_fetch_req  = 1'b0;
  endtask

  initial begin
    i_rst = 1'b1; i_fetch_req = 1'b0; i_fetch_addr = 32'd0;
    i_load_start = 1'b0; i_load_base = 32'd0; i_load_count = 16'd0;
    i_load_valid = 1'b0; i_load_data = 32'd0;
    tick(); tick();

    chk("rst_inst", o_inst_read, 32'h0);
    chk("rst_fault", {31'd0, o_fetch_fault}, 32'd0);
    chk("rst_ready", {31'd0, o_load_ready}, 32'd0);
    chk("rst_busy", {31'd0, o_load_busy}, 32'd0);
    chk("rst_done", {31'd0, o_load_done}, 32'd0);
    chk("rst_err", {31'd0, o_load_err}, 32'd0);
    i_rst = 1'b0;
    tick();

    // Burst of four words at base 0
    start_load(32'h0, 16'd4);
    chk("ld4_ready", {31'd0, o_load_ready}, 32'd1);
    chk("ld4_busy", {31'd0, o_load_busy}, 32'd1);
    send_beat(32'hA000_0000);
    send_beat(32'hA000_0001);
    send_beat(32'hA000_0002);
    chk("ld4_done_early", {31'd0, o_load_done}, 32'd0);
    send_beat(32'hA000_0003);
    chk("ld4_done", {31'd0, o_load_done}, 32'd1);
    chk("ld4_err", {31'd0, o_load_err}, 32'd0);
    chk("ld4_busy_done", {31'd0, o_load_busy}, 32'd0);
    chk("ld4_ready_done", {31'd0, o_load_ready}, 32'd0);
    tick();
    chk("ld4_done_pulse", {31'd0, o_load_done}, 32'd0);
    fetch(32'h8);
    chk("fetch_8", o_inst_read, 32'hA000_0002);
    chk("fetch_8_fault", {31'd0, o_fetch_fault}, 32'd0);

    // Fault cases
    fetch(32'h6);
    chk("fetch_6", o_inst_read, 32'h0);
    chk("fetch_6_fault", {31'd0, o_fetch_fault}, 32'd1);
    i_fetch_addr = 32'h0;
    tick();
    chk("fault_hold", {31'd0, o_fetch_fault}, 32'd1);
    fetch(32'h1000);
    chk("fetch_1000", o_inst_read, 32'h0);
    chk("fetch_1000_fault", {31'd0, o_fetch_fault}, 32'd1);
    fetch(32'hFFFF_FFFC);
    chk("fetch_neg_fault", {31'd0, o_fetch_fault}, 32'd1);

    // Hold when no request
    fetch(32'h4);
    chk("hold_0", o_inst_read, 32'hA000_0001);
    i_fetch_addr = 32'h8;
    for (int i = 1; i <= 3; i++) begin
      tick();
      chk($sformatf("hold_%0d", i), o_inst_read, 32'hA000_0001);
    end

    // Same-edge write and read of word 3
    start_load(32'hC, 16'd1);
    i_fetch_req = 1'b1; i_fetch_addr = 32'hC;
    send_beat(32'hDEAD_BEEF);
    i_fetch_req = 1'b0;
    chk("rf_old", o_inst_read, 32'hA000_0003);
    chk("rf_done", {31'd0, o_load_done}, 32'd1);
    fetch(32'hC);
    chk("rf_new", o_inst_read, 32'hDEAD_BEEF);

    // Fill words 4..7
    start_load(32'h10, 16'd4);
    for (int i = 4; i < 8; i++) send_beat(32'hB000_0000 | 32'(i));
    tick();

    // Reset mid-burst
    start_load(32'h0, 16'd8);
    for (int i = 0; i < 3; i++) send_beat(32'hC000_0000 | 32'(i));
    i_rst = 1'b1; i_load_valid = 1'b1; i_load_data = 32'hC000_0003;
    i_fetch_req = 1'b1; i_fetch_addr = 32'h4;
    tick();
    i_rst = 1'b0; i_load_valid = 1'b0; i_fetch_req = 1'b0;
    chk("mid_rst_inst", o_inst_read, 32'h0);
    chk("mid_rst_fault", {31'd0, o_fetch_fault}, 32'd0);
    chk("mid_rst_ready", {31'd0, o_load_ready}, 32'd0);
    chk("mid_rst_busy", {31'd0, o_load_busy}, 32'd0);
    chk("mid_rst_done", {31'd0, o_load_done}, 32'd0);
    chk("mid_rst_err", {31'd0, o_load_err}, 32'd0);
    send_beat(32'hC000_0004);
    chk("mid_rst_idle_ready", {31'd0, o_load_ready}, 32'd0);
    begin
      logic [31:0] exp_words [8];
      exp_words = '{32'hC000_0000, 32'hC000_0001, 32'hC000_0002, 32'hDEAD_BEEF,
                    32'hB000_0004, 32'hB000_0005, 32'hB000_0006, 32'hB000_0007};
      for (int i = 0; i < 8; i++) begin
        fetch(32'(i * 4));
        chk($sformatf("after_rst_w%0d", i), o_inst_read, exp_words[i]);
      end
    end

    // Burst straddling the top of memory
    start_load(32'hFF8, 16'd4);
    send_beat(32'hE000_0000);
    send_beat(32'hE000_0001);
    chk("top_err_ok", {31'd0, o_load_err}, 32'd0);
    send_beat(32'hE000_0002);
    chk("top_err_set", {31'd0, o_load_err}, 32'd1);
    chk("top_done_early", {31'd0, o_load_done}, 32'd0);
    send_beat(32'hE000_0003);
    chk("top_done", {31'd0, o_load_done}, 32'd1);
    tick();
    chk("top_done_pulse", {31'd0, o_load_done}, 32'd0);
    chk("top_err_sticky", {31'd0, o_load_err}, 32'd1);
    fetch(32'hFF8);
    chk("top_ff8", o_inst_read, 32'hE000_0000);
    fetch(32'hFFC);
    chk("top_ffc", o_inst_read, 32'hE000_0001);
    chk("top_ffc_fault", {31'd0, o_fetch_fault}, 32'd0);
    fetch(32'h0);
    chk("top_no_wrap0", o_inst_read, 32'hC000_0000);
    fetch(32'h4);
    chk("top_no_wrap1", o_inst_read, 32'hC000_0001);

    // Zero-count start goes straight to DONE
    start_load(32'h40, 16'd0);
    chk("zero_done", {31'd0, o_load_done}, 32'd1);
    chk("zero_busy", {31'd0, o_load_busy}, 32'd0);
    chk("zero_ready", {31'd0, o_load_ready}, 32'd0);
    tick();
    chk("zero_done_pulse", {31'd0, o_load_done}, 32'd0);

    // New start clears err; start during LOAD is ignored
    start_load(32'h20, 16'd1);
    chk("restart_err_clr", {31'd0, o_load_err}, 32'd0);
    start_load(32'h40, 16'd5);
    chk("ignore_start_busy", {31'd0, o_load_busy}, 32'd1);
    send_beat(32'hF000_0000);
    chk("ignore_start_done", {31'd0, o_load_done}, 32'd1);
    fetch(32'h20);
    chk("ignore_start_w20", o_inst_read, 32'hF000_0000);
    chk("ignore_start_idle", {31'd0, o_load_busy}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
